// File: rtl/alu_ctrl_arbiter_pkg.sv
// Shared definitions for the ALU command scheduler: FSM states and the
// unit-select encoding carried in ALU_FUN[3:2].
package alu_ctrl_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [1:0] UNIT_ARITH = 2'b00;
  localparam logic [1:0] UNIT_LOGIC = 2'b01;
  localparam logic [1:0] UNIT_CMP   = 2'b10;
  localparam logic [1:0] UNIT_SHIFT = 2'b11;

  // Unit selected by a function code.
  function automatic logic [1:0] unit_of(input logic [3:0] fun);
    return fun[3:2];
  endfunction

endpackage

// File: rtl/alu_rr_arb2.sv
// Two-way round-robin arbiter.
// Ports:
//   clk, rst_n        clock / async active-low reset
//   en_i              arbitration enabled (scheduler idle)
//   req_valid_i[1:0]  request valids
//   grant_c_o[1:0]    combinational one-hot (or zero) grant
//   accept_c_o        granted requester is valid this cycle
//   grant_idx_c_o     index of the granted requester
module alu_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [1:0] req_valid_i,
  output logic [1:0] grant_c_o,
  output logic       accept_c_o,
  output logic       grant_idx_c_o
);

  // prio_q = 1 means requester 1 wins a tie; reset favours requester 0.
  logic prio_q, prio_d;

  // Grant: a lone valid always wins; a tie goes to the priority holder.
  always_comb begin
    grant_c_o = 2'b00;
    if (en_i) begin
      if (&req_valid_i) begin
        grant_c_o = prio_q ? 2'b10 : 2'b01;
      end else begin
        grant_c_o = req_valid_i;
      end
    end
  end

  assign accept_c_o    = |(grant_c_o & req_valid_i);
  assign grant_idx_c_o = grant_c_o[1];

  // Pointer moves only on a real accept, so a dropped request costs nothing.
  always_comb begin
    prio_d = prio_q;
    if (accept_c_o) begin
      prio_d = ~grant_idx_c_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/alu_ctrl_arbiter.sv
// Two-requester command scheduler for the shared ALU datapath.
// One command in flight: arbitrate, drive ALU_A/ALU_B/ALU_FUN, wait the unit
// latency, capture the unit result picked by ALU_FUN[3:2], return it tagged.
// Ports:
//   CLK, RST                       clock / async active-low reset
//   req_valid/req_ready[1:0]       command handshake per requester
//   req_a*/req_b*/req_fun*         operands and function code per requester
//   rsp_valid/rsp_ready            response handshake
//   rsp_id/rsp_data/rsp_carry/rsp_err  response payload
//   ALU_A/ALU_B/ALU_FUN            operands and function to the ALU
//   Arith/Logic/Shift/CMP_OUT, *_FLAG, Carry_OUT  ALU results and flags
// Build option: ALU_CTRL_FLAGCHK_EN enables the selected-unit flag check.
module alu_ctrl_arbiter
  import alu_ctrl_arbiter_pkg::*;
#(
  parameter int unsigned INDATA_WIDTH = 16,
  parameter int unsigned ALU_LAT      = 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [INDATA_WIDTH-1:0]   req_a0,
  input  logic [INDATA_WIDTH-1:0]   req_b0,
  input  logic [INDATA_WIDTH-1:0]   req_a1,
  input  logic [INDATA_WIDTH-1:0]   req_b1,
  input  logic [3:0]                req_fun0,
  input  logic [3:0]                req_fun1,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_id,
  output logic [2*INDATA_WIDTH-1:0] rsp_data,
  output logic                      rsp_carry,
  output logic                      rsp_err,
  output logic [INDATA_WIDTH-1:0]   ALU_A,
  output logic [INDATA_WIDTH-1:0]   ALU_B,
  output logic [3:0]                ALU_FUN,
  input  logic [2*INDATA_WIDTH-1:0] Arith_OUT,
  input  logic [INDATA_WIDTH-1:0]   Logic_OUT,
  input  logic [INDATA_WIDTH-1:0]   Shift_OUT,
  input  logic [2:0]                CMP_OUT,
  input  logic                      Arith_FLAG,
  input  logic                      Logic_FLAG,
  input  logic                      Shift_FLAG,
  input  logic                      CMP_FLAG,
  input  logic                      Carry_OUT
);

  localparam int unsigned RW    = 2 * INDATA_WIDTH;
  localparam int unsigned CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT + 1) : 1;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [INDATA_WIDTH-1:0] alu_a_q, alu_a_d;
  logic [INDATA_WIDTH-1:0] alu_b_q, alu_b_d;
  logic [3:0]              alu_fun_q, alu_fun_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_id_q, rsp_id_d;
  logic [RW-1:0]           rsp_data_q, rsp_data_d;
  logic                    rsp_carry_q, rsp_carry_d;
  logic                    rsp_err_q, rsp_err_d;

  logic [1:0]              grant_c;
  logic                    accept_c;
  logic                    grant_idx_c;
  logic [RW-1:0]           sel_data_c;
  logic                    sel_carry_c;
  logic                    err_c;

  // Arbitration only runs while idle; outside IDLE both readies are low.
  alu_rr_arb2 u_arb (
    .clk           (CLK),
    .rst_n         (RST),
    .en_i          (state_q == ST_IDLE),
    .req_valid_i   (req_valid),
    .grant_c_o     (grant_c),
    .accept_c_o    (accept_c),
    .grant_idx_c_o (grant_idx_c)
  );

  assign req_ready = grant_c;

  // Result select by unit; narrower results are zero-extended.
  always_comb begin
    sel_data_c  = '0;
    sel_carry_c = 1'b0;
    case (unit_of(alu_fun_q))
      UNIT_ARITH: begin
        sel_data_c  = Arith_OUT;
        sel_carry_c = Carry_OUT;
      end
      UNIT_LOGIC: sel_data_c = RW'(Logic_OUT);
      UNIT_CMP:   sel_data_c = RW'(CMP_OUT);
      default:    sel_data_c = RW'(Shift_OUT);
    endcase
  end

`ifdef ALU_CTRL_FLAGCHK_EN
  logic sel_flag_c;

  // The selected unit must report its flag set, otherwise the result is void.
  always_comb begin
    sel_flag_c = 1'b1;
    case (unit_of(alu_fun_q))
      UNIT_ARITH: sel_flag_c = Arith_FLAG;
      UNIT_LOGIC: sel_flag_c = Logic_FLAG;
      UNIT_CMP:   sel_flag_c = CMP_FLAG;
      default:    sel_flag_c = Shift_FLAG;
    endcase
  end

  assign err_c = ~sel_flag_c;
`else
  logic unused_flags;

  assign unused_flags = ^{Arith_FLAG, Logic_FLAG, Shift_FLAG, CMP_FLAG};
  assign err_c        = 1'b0;
`endif

  // Scheduler FSM: IDLE -> EXEC (ALU_LAT+1 cycles) -> RESP -> IDLE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_fun_d   = alu_fun_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          alu_a_d   = grant_idx_c ? req_a1   : req_a0;
          alu_b_d   = grant_idx_c ? req_b1   : req_b0;
          alu_fun_d = grant_idx_c ? req_fun1 : req_fun0;
          rsp_id_d  = grant_idx_c;
          cnt_d     = '0;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q == CNT_W'(ALU_LAT)) begin
          rsp_data_d  = err_c ? '0 : sel_data_c;
          rsp_carry_d = sel_carry_c;
          rsp_err_d   = err_c;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fun_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_fun_q   <= alu_fun_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign ALU_A     = alu_a_q;
  assign ALU_B     = alu_b_q;
  assign ALU_FUN   = alu_fun_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_ctrl_arbiter.sv
// Scoreboard bench for alu_ctrl_arbiter: a latency-ALU_LAT ALU model feeds the
// result ports, a reference model predicts grants and responses at accept,
// and a negedge monitor compares every grant and every presented response.
module tb_alu_ctrl_arbiter;

  localparam int unsigned W   = 16;
  localparam int unsigned RW  = 2 * W;
  localparam int unsigned LAT = 1;

  typedef struct packed {
    logic          id;
    logic [RW-1:0] data;
    logic          carry;
    logic          err;
  } exp_t;

  logic          CLK, RST;
  logic [1:0]    req_valid, req_ready;
  logic [W-1:0]  req_a0, req_b0, req_a1, req_b1;
  logic [3:0]    req_fun0, req_fun1;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_err;
  logic [RW-1:0] rsp_data;
  logic [W-1:0]  ALU_A, ALU_B;
  logic [3:0]    ALU_FUN;
  logic [RW-1:0] Arith_OUT;
  logic [W-1:0]  Logic_OUT, Shift_OUT;
  logic [2:0]    CMP_OUT;
  logic          Arith_FLAG, Logic_FLAG, Shift_FLAG, CMP_FLAG, Carry_OUT;

  logic [W-1:0]  drv_a [2];
  logic [W-1:0]  drv_b [2];
  logic [3:0]    drv_f [2];
  logic [1:0]    drv_v;

  assign req_a0    = drv_a[0];
  assign req_b0    = drv_b[0];
  assign req_fun0  = drv_f[0];
  assign req_a1    = drv_a[1];
  assign req_b1    = drv_b[1];
  assign req_fun1  = drv_f[1];
  assign req_valid = drv_v;

  alu_ctrl_arbiter #(.INDATA_WIDTH(W), .ALU_LAT(LAT)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_fun0(req_fun0), .req_fun1(req_fun1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN),
    .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT), .Shift_OUT(Shift_OUT),
    .CMP_OUT(CMP_OUT), .Arith_FLAG(Arith_FLAG), .Logic_FLAG(Logic_FLAG),
    .Shift_FLAG(Shift_FLAG), .CMP_FLAG(CMP_FLAG), .Carry_OUT(Carry_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ALU behaviour (unit functions)
  function automatic logic [RW-1:0] arith_f(input logic [W-1:0] a, b, input logic [3:0] f);
    case (f[1:0])
      2'b00:   return RW'(a) + RW'(b);
      2'b01:   return RW'(W'(a - b));
      2'b10:   return RW'(a) * RW'(b);
      default: return {a, b};
    endcase
  endfunction

  function automatic logic carry_f(input logic [W-1:0] a, b, input logic [3:0] f);
    logic [RW-1:0] s;
    s = RW'(a) + RW'(b);
    if (f[1:0] == 2'b00) return s[W];
    if (f[1:0] == 2'b01) return (a < b);
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] logic_f(input logic [W-1:0] a, b, input logic [3:0] f);
    case (f[1:0])
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  function automatic logic [2:0] cmp_f(input logic [W-1:0] a, b);
    return {a > b, a < b, a == b};
  endfunction

  function automatic logic [W-1:0] shift_f(input logic [W-1:0] a, input logic [3:0] f);
    case (f[1:0])
      2'b00:   return {a[0], a[W-1:1]};
      2'b01:   return {a[W-2:0], a[W-1]};
      2'b10:   return a >> 1;
      default: return a << 1;
    endcase
  endfunction

  // A unit's flag is low when both operands have its bit set (unit 0..3).
  function automatic logic flag_f(input logic [W-1:0] a, b, input int unit);
    return ~(a[unit] & b[unit]);
  endfunction

  // ALU register pipeline of depth LAT on the operand/function inputs.
  logic [W-1:0] pa [LAT];
  logic [W-1:0] pb [LAT];
  logic [3:0]   pf [LAT];

  always @(posedge CLK) begin
    pa[0] <= ALU_A;
    pb[0] <= ALU_B;
    pf[0] <= ALU_FUN;
    for (int i = 1; i < LAT; i++) begin
      pa[i] <= pa[i-1];
      pb[i] <= pb[i-1];
      pf[i] <= pf[i-1];
    end
  end

  always_comb begin
    Arith_OUT  = arith_f(pa[LAT-1], pb[LAT-1], pf[LAT-1]);
    Carry_OUT  = carry_f(pa[LAT-1], pb[LAT-1], pf[LAT-1]);
    Logic_OUT  = logic_f(pa[LAT-1], pb[LAT-1], pf[LAT-1]);
    CMP_OUT    = cmp_f(pa[LAT-1], pb[LAT-1]);
    Shift_OUT  = shift_f(pa[LAT-1], pf[LAT-1]);
    Arith_FLAG = flag_f(pa[LAT-1], pb[LAT-1], 0);
    Logic_FLAG = flag_f(pa[LAT-1], pb[LAT-1], 1);
    CMP_FLAG   = flag_f(pa[LAT-1], pb[LAT-1], 2);
    Shift_FLAG = flag_f(pa[LAT-1], pb[LAT-1], 3);
  end

  // Reference model of the expected response for an accepted command.
  function automatic exp_t model_rsp(input logic [W-1:0] a, b, input logic [3:0] f, input logic id);
    exp_t e;
    logic flag;
    e.id    = id;
    e.carry = 1'b0;
    e.err   = 1'b0;
    case (f[3:2])
      2'b00: begin
        e.data  = arith_f(a, b, f);
        e.carry = carry_f(a, b, f);
        flag    = flag_f(a, b, 0);
      end
      2'b01: begin e.data = {16'h0000, logic_f(a, b, f)}; flag = flag_f(a, b, 1); end
      2'b10: begin e.data = {29'd0, cmp_f(a, b)};         flag = flag_f(a, b, 2); end
      default: begin e.data = {16'h0000, shift_f(a, f)};  flag = flag_f(a, b, 3); end
    endcase
`ifdef ALU_CTRL_FLAGCHK_EN
    if (!flag) begin
      e.err  = 1'b1;
      e.data = '0;
    end
`else
    if (flag) e.err = 1'b0;
`endif
    return e;
  endfunction

  // Round-robin rule: lone request wins; tie goes to whoever was not last granted.
  function automatic logic [1:0] model_grant(input logic [1:0] v, input logic last1);
    if (v == 2'b11) return last1 ? 2'b01 : 2'b10;
    return v;
  endfunction

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  exp_t sb[$];
  logic busy_m  = 1'b0;
  logic last1_m = 1'b1;   // reset state: as if requester 1 was last granted
  logic seen_m  = 1'b0;
  int   acc_cyc = 0;

  always @(negedge CLK) begin
    exp_t e;
    logic g;
    if (!RST) begin
      sb.delete();
      busy_m  = 1'b0;
      last1_m = 1'b1;
      seen_m  = 1'b0;
    end else begin
      if (busy_m) chk("ready_while_busy", 64'(req_ready), 64'd0);
      else        chk("grant", 64'(req_ready), 64'(model_grant(req_valid, last1_m)));
      if (|(req_valid & req_ready)) begin
        g = req_ready[1];
        sb.push_back(model_rsp(drv_a[g], drv_b[g], drv_f[g], g));
        busy_m  = 1'b1;
        last1_m = g;
        acc_cyc = cyc;
        seen_m  = 1'b0;
      end
      if (rsp_valid) begin
        if (!seen_m) begin
          // Capture on the last EXEC cycle; visible one cycle later.
          chk("latency", 64'(cyc - acc_cyc), 64'(LAT + 2));
          seen_m = 1'b1;
        end
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          e = sb[0];
          chk("rsp_id", 64'(rsp_id), 64'(e.id));
          chk("rsp_data", 64'(rsp_data), 64'(e.data));
          chk("rsp_carry", 64'(rsp_carry), 64'(e.carry));
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
          if (rsp_ready) begin
            void'(sb.pop_front());
            busy_m = 1'b0;
          end
        end
      end else if (busy_m && !seen_m && (cyc - acc_cyc > int'(LAT) + 2)) begin
        chk("rsp_timeout", 64'(rsp_valid), 64'd1);
        seen_m = 1'b1;
      end
    end
  end

  // Stimulus helpers (all return at posedge + 1)
  task automatic new_cmd(input int p, input bit logic_only);
    drv_a[p] = W'($urandom);
    drv_b[p] = W'($urandom);
    if ($urandom_range(3) == 0) drv_a[p] = W'($urandom_range(15));
    if ($urandom_range(3) == 0) drv_b[p] = drv_a[p];
    drv_f[p] = logic_only ? {2'b01, 2'($urandom_range(3))} : 4'($urandom_range(15));
  endtask

  task automatic issue(input int p, input logic [W-1:0] a, b, input logic [3:0] f);
    drv_a[p] = a;
    drv_b[p] = b;
    drv_f[p] = f;
    drv_v[p] = 1'b1;
  endtask

  task automatic wait_accept(input int p);
    bit done = 0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge CLK);
      if (req_valid[p] && req_ready[p]) done = 1;
      @(posedge CLK); #1;
    end
    if (!done) chk("accept_timeout", 64'(p), 64'(p + 10));
    drv_v[p] = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge CLK); #1;
      if (!busy_m && sb.size() == 0) done = 1;
    end
    if (!done) chk("idle_timeout", 64'(sb.size()), 64'd0);
    @(posedge CLK); #1;
  endtask

  // mode 0: random traffic; mode 1: both valid, logic ops, rsp_ready high
  task automatic run_cycles(input int n, input int mode);
    for (int k = 0; k < n; k++) begin
      logic [1:0] acc;
      @(negedge CLK);
      acc = req_valid & req_ready;
      @(posedge CLK); #1;
      for (int p = 0; p < 2; p++) begin
        if (mode == 1) begin
          if (acc[p] || !drv_v[p]) new_cmd(p, 1'b1);
          drv_v[p] = 1'b1;
        end else if (acc[p] || !drv_v[p]) begin
          if ($urandom_range(2) == 0) begin
            new_cmd(p, 1'b0);
            drv_v[p] = 1'b1;
          end else begin
            drv_v[p] = 1'b0;
          end
        end else if ($urandom_range(15) == 0) begin
          drv_v[p] = 1'b0;
        end
      end
      rsp_ready = (mode == 1) ? 1'b1 : ($urandom_range(3) != 0);
    end
  endtask

  initial begin
    RST       = 1'b0;
    rsp_ready = 1'b0;
    drv_v     = 2'b00;
    for (int p = 0; p < 2; p++) begin
      drv_a[p] = '0;
      drv_b[p] = '0;
      drv_f[p] = '0;
    end
    #2;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_data", 64'(rsp_data), 64'd0);
    chk("reset_rsp_id", 64'(rsp_id), 64'd0);
    chk("reset_alu_a", 64'(ALU_A), 64'd0);
    chk("reset_alu_b", 64'(ALU_B), 64'd0);
    chk("reset_alu_fun", 64'(ALU_FUN), 64'd0);
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;

    // Single multiply 3*4 from requester 0
    rsp_ready = 1'b1;
    issue(0, 16'h0003, 16'h0004, 4'b0010);
    wait_accept(0);
    wait_idle();

    // Shift op on requester 1: rotate-right of 3 gives 16'h8001, Arith differs
    issue(1, 16'h0003, 16'hFFFF, 4'b1100);
    wait_accept(1);
    wait_idle();

    // Compare with equal odd operands: CMP_FLAG low
    issue(0, 16'h0007, 16'h0007, 4'b1000);
    wait_accept(0);
    wait_idle();

    // Contention with logic ops: grants must alternate
    run_cycles(40, 1);
    drv_v = 2'b00;
    wait_idle();

    // Backpressure: hold rsp_ready low while the other requester waits
    rsp_ready = 1'b0;
    issue(0, 16'h1234, 16'h00FF, 4'b0100);
    wait_accept(0);
    issue(1, 16'hF0F0, 16'h0F0F, 4'b0001);
    for (int k = 0; k < 20 && !rsp_valid; k++) begin
      @(posedge CLK); #1;
    end
    repeat (5) begin
      @(negedge CLK);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      @(posedge CLK); #1;
    end
    rsp_ready = 1'b1;
    wait_accept(1);
    wait_idle();

    // Random traffic
    run_cycles(600, 0);
    drv_v     = 2'b00;
    rsp_ready = 1'b1;
    wait_idle();

    // Reset during EXEC: command dropped, outputs cleared at once
    issue(1, 16'hABCD, 16'h1111, 4'b0000);
    wait_accept(1);
    RST   = 1'b0;
    drv_v = 2'b00;
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_alu_a", 64'(ALU_A), 64'd0);
    chk("rst_alu_b", 64'(ALU_B), 64'd0);
    chk("rst_alu_fun", 64'(ALU_FUN), 64'd0);
    @(posedge CLK); #1;
    issue(0, 16'h0005, 16'h0006, 4'b0110);
    issue(1, 16'h0009, 16'h0002, 4'b0111);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK);
    chk("post_reset_grant", 64'(req_ready), 64'd1);
    @(posedge CLK); #1;
    drv_v[0] = 1'b0;
    wait_accept(1);
    wait_idle();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got t=%0t expected finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
